// File: rtl/lut_out_drain.sv
// lut_out_drain: reads a K*HW tile from the output buffer in address order and streams it out.
// Reads are throttled so that returning data always fits in the skid FIFO. The FIFO absorbs
// downstream backpressure.
`ifndef HW_BS_OUT_BUF_DEPTH
`define HW_BS_OUT_BUF_DEPTH 16
`endif

module lut_out_drain #(
  parameter int unsigned BS_OUT_BUF_DEPTH = `HW_BS_OUT_BUF_DEPTH,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned RD_LAT           = 2,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bs_wb_tile_start,
  input  logic [7:0]                  bs_subtile_K,
  input  logic [7:0]                  bs_subtile_HW,
  output logic                        bs_out_buf_rd_en,
  output logic [BS_OUT_BUF_DEPTH-1:0] bs_out_buf_rd_addr,
  input  logic [DATA_W-1:0]           bs_out_buf_rd_data,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        bs_wb_busy,
  output logic                        bs_wb_tile_end
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FlW  = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [15:0]       total_q;
  logic [15:0]       addr_q;
  logic [15:0]       beat_q;
  logic [RD_LAT-1:0] ret_q;
  logic [FlW-1:0]    in_flight_q;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              end_q;

  logic [15:0] start_total;
  logic [15:0] addr_sel;
  logic        start_ok;
  logic        credit;
  logic        rd_en;
  logic        push;
  logic        pop;
  logic        fifo_nempty;
  logic        last_beat;

  // Read issue, FIFO handshake and output decode.
  always_comb begin
    start_total = 16'(bs_subtile_K) * 16'(bs_subtile_HW);
    start_ok    = (state_q == StIdle) && bs_wb_tile_start;
    credit      = (int'(in_flight_q) + int'(count_q)) < int'(FIFO_DEPTH);
    // The first read goes out in the start cycle itself so the first beat lands RD_LAT+1 later.
    rd_en       = ~rst & ((start_ok & (start_total != 16'd0)) | ((state_q == StIssue) & credit));
    push        = ret_q[RD_LAT-1];
    fifo_nempty = (count_q != '0);
    pop         = fifo_nempty & m_ready & ~rst;
    last_beat   = (beat_q == total_q - 16'd1);
    addr_sel    = (state_q == StIdle) ? 16'd0 : addr_q;

    bs_out_buf_rd_en   = rd_en;
    bs_out_buf_rd_addr = rd_en ? BS_OUT_BUF_DEPTH'(addr_sel) : '0;
    m_valid            = fifo_nempty & ~rst;
    m_data             = m_valid ? fifo_q[rd_ptr_q] : '0;
    m_last             = m_valid & last_beat;
    bs_wb_busy         = (state_q != StIdle) & ~rst;
    bs_wb_tile_end     = end_q & ~rst;
  end

  // Skid FIFO storage; occupancy is tracked by the control block, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bs_out_buf_rd_data;
    end
  end

  // Sequencing FSM, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      total_q     <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      ret_q       <= '0;
      in_flight_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      end_q       <= 1'b0;
    end else begin
      end_q       <= 1'b0;
      ret_q       <= (ret_q << 1) | RD_LAT'(rd_en);
      in_flight_q <= in_flight_q + FlW'(rd_en) - FlW'(push);
      count_q     <= count_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            total_q <= start_total;
            beat_q  <= '0;
            if (start_total == 16'd0) begin
              addr_q <= '0;
              end_q  <= 1'b1;
            end else begin
              // Address 0 was issued this cycle.
              addr_q  <= 16'd1;
              state_q <= (start_total == 16'd1) ? StDrain : StIssue;
            end
          end
        end
        StIssue: begin
          if (rd_en) begin
            addr_q <= addr_q + 16'd1;
            if (addr_q == total_q - 16'd1) state_q <= StDrain;
          end
        end
        StDrain: ;
        default: state_q <= StIdle;
      endcase

      if (pop) begin
        beat_q <= beat_q + 16'd1;
        if (last_beat) begin
          state_q <= StIdle;
          end_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_out_drain.sv
// tb_lut_out_drain: directed tiles against a transaction-level model of the drain engine.
module tb_lut_out_drain;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned FD     = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    k;
  logic [7:0]    hw;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          tile_end;

  always #5 clk = ~clk;

  lut_out_drain #(
    .BS_OUT_BUF_DEPTH(AW),
    .DATA_W          (DW),
    .RD_LAT          (RD_LAT),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bs_wb_tile_start  (start),
    .bs_subtile_K      (k),
    .bs_subtile_HW     (hw),
    .bs_out_buf_rd_en  (rd_en),
    .bs_out_buf_rd_addr(rd_addr),
    .bs_out_buf_rd_data(rd_data),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .bs_wb_busy        (busy),
    .bs_wb_tile_end    (tile_end)
  );

  // Output buffer: word at address a of the tile tagged t reads back as {t, a}.
  logic [15:0] tag;
  logic        p_v [RD_LAT];
  logic [15:0] p_a [RD_LAT];
  logic [15:0] p_t [RD_LAT];

  always @(posedge clk) begin
    p_v[0] <= rd_en;
    p_a[0] <= rd_addr;
    p_t[0] <= tag;
    for (int i = 1; i < RD_LAT; i++) begin
      p_v[i] <= p_v[i-1];
      p_a[i] <= p_a[i-1];
      p_t[i] <= p_t[i-1];
    end
  end

  assign rd_data = (p_v[RD_LAT-1] === 1'b1) ? {p_t[RD_LAT-1], p_a[RD_LAT-1]} : 32'hBAD0_BAD0;

  int vec_n = 0;
  int bad_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad_n++;
      if (bad_n <= 100) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model state and per-run statistics, owned by the monitor.
  logic        md_active = 1'b0;
  logic        md_end_due = 1'b0;
  logic [15:0] md_total = '0;
  logic [15:0] md_tag = '0;
  logic [15:0] md_addr = '0;
  logic [15:0] md_beat = '0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int cyc = 0;
  int s_beats = 0, s_rds = 0, s_ends = 0, s_lasts = 0;
  int s_start_cyc = 0, s_first_cyc = 0, s_last_cyc = 0, s_end_cyc = 0;
  int s_max_addr = 0;

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("reset_outputs", {rd_en, rd_addr, m_valid, m_last, m_data, busy, tile_end}, '0);
        md_active  = 1'b0;
        md_end_due = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("tile_end", tile_end, md_end_due);
        if (tile_end) begin
          s_ends++;
          s_end_cyc = cyc;
        end
        md_end_due = 1'b0;
        chk("busy", busy, md_active);
        if (!md_active) chk("idle_valid", m_valid, 1'b0);
        if (prev_stall) chk("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
        if (!md_active && start) begin
          md_total    = 16'(k) * 16'(hw);
          md_tag      = tag;
          md_addr     = '0;
          md_beat     = '0;
          s_start_cyc = cyc;
          if (md_total == 16'd0) md_end_due = 1'b1;
          else md_active = 1'b1;
        end
        if (rd_en) begin
          s_rds++;
          chk("rd_addr", {md_active, rd_addr}, {1'b1, md_addr});
          if (int'(rd_addr) > s_max_addr) s_max_addr = int'(rd_addr);
          md_addr++;
        end
        if (md_active) chk("fifo_bound", (int'(md_addr) - int'(md_beat)) <= int'(FD), 1'b1);
        if (m_valid) begin
          chk("m_last", m_last, md_beat == md_total - 16'd1);
          if (m_ready) begin
            chk("m_data", m_data, {md_tag, md_beat});
            if (md_beat == 16'd0) s_first_cyc = cyc;
            s_beats++;
            if (m_last) s_lasts++;
            if (md_beat == md_total - 16'd1) begin
              md_active  = 1'b0;
              md_end_due = 1'b1;
              s_last_cyc = cyc;
            end
            md_beat++;
          end
        end else begin
          chk("m_last_idle", m_last, 1'b0);
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
      end
    end
  endtask

  logic rdy_rand = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start(input logic [7:0] kv, input logic [7:0] hv, input logic [15:0] tg);
    k     = kv;
    hw    = hv;
    tag   = tg;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int e0 = s_ends;
    int n  = 0;
    while (s_ends == e0 && n < budget) begin
      step();
      n++;
    end
    chk(name, s_ends != e0, 1'b1);
  endtask

  int b0, r0, e0, l0;

  initial begin
    rst = 1'b1; start = 1'b0; k = '0; hw = '0; m_ready = 1'b1; tag = '0;
    fork
      monitor();
    join_none
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic drain, data equals address.
    b0 = s_beats; l0 = s_lasts;
    pulse_start(8'd2, 8'd3, 16'h0000);
    wait_end(50, "basic_timeout");
    chk("basic_beats", s_beats - b0, 6);
    chk("basic_lasts", s_lasts - l0, 1);
    chk("basic_first_lat", s_first_cyc - s_start_cyc, RD_LAT + 1);
    chk("basic_no_gaps", s_last_cyc - s_first_cyc, 5);
    chk("basic_end_lat", s_end_cyc - s_last_cyc, 1);
    step();

    // Backpressure.
    b0 = s_beats; l0 = s_lasts;
    rdy_rand = 1'b1;
    pulse_start(8'd4, 8'd4, 16'h0001);
    wait_end(400, "bp_timeout");
    rdy_rand = 1'b0;
    m_ready  = 1'b1;
    chk("bp_beats", s_beats - b0, 16);
    chk("bp_lasts", s_lasts - l0, 1);
    step();

    // Zero tile.
    b0 = s_beats; r0 = s_rds; e0 = s_ends;
    pulse_start(8'd0, 8'd5, 16'h0002);
    repeat (6) step();
    chk("zero_rds", s_rds - r0, 0);
    chk("zero_beats", s_beats - b0, 0);
    chk("zero_ends", s_ends - e0, 1);
    chk("zero_end_lat", s_end_cyc - s_start_cyc, 1);

    // Start while busy is ignored.
    b0 = s_beats; e0 = s_ends;
    pulse_start(8'd3, 8'd4, 16'h0003);
    repeat (3) step();
    pulse_start(8'd5, 8'd5, 16'h0003);
    wait_end(100, "busy_timeout");
    repeat (20) step();
    chk("busy_beats", s_beats - b0, 12);
    chk("busy_ends", s_ends - e0, 1);

    // Reset mid-tile, then a fresh small tile.
    b0 = s_beats; e0 = s_ends;
    pulse_start(8'd2, 8'd4, 16'h0004);
    for (int n = 0; n < 50 && (s_beats - b0) < 3; n++) step();
    chk("rst_pre_beats", s_beats - b0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    b0 = s_beats;
    pulse_start(8'd1, 8'd2, 16'h0005);
    wait_end(50, "rst_timeout");
    repeat (10) step();
    chk("rst_beats", s_beats - b0, 2);
    chk("rst_ends", s_ends - e0, 1);

    // Maximum tile.
    b0 = s_beats; r0 = s_rds; l0 = s_lasts;
    pulse_start(8'd255, 8'd255, 16'h0006);
    wait_end(70000, "max_timeout");
    chk("max_beats", s_beats - b0, 65025);
    chk("max_rds", s_rds - r0, 65025);
    chk("max_lasts", s_lasts - l0, 1);
    chk("max_addr", s_max_addr, 65024);
    chk("max_no_gaps", s_last_cyc - s_first_cyc, 65024);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end

endmodule
